riscv_apu_slave: RTL and testbench

- Responder end of the APU request/response handshake; sits on the interconnect opposite the core-side dispatcher.
- Grants requests, computes the result of a small integer operation set, and holds each operation for a latency class chosen per request.
- Returns results strictly in acceptance order with their 6-bit write-address tag.
- Buffers up to DEPTH outstanding operations and honours response-side backpressure.

---
 rtl/riscv_apu_slave.sv | 212 +++++++++++++++++++++
 tb/tb_riscv_apu_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_apu_slave.sv
// -----------------------------------------------------------------------------
// riscv_apu_slave
//
// Responder side of the APU request/response handshake. Accepted requests are
// evaluated immediately: ADD and SUB wrap, MUL keeps the low WIDTH bits, and
// MIN is a signed minimum. The result is parked in a small in-order queue
// until its latency class has elapsed, and then returned with its tag.
// Results always leave in acceptance order. A single-cycle request that
// arrives at an idle slave with the response side ready is returned in the
// same cycle without touching the queue.
//
// Ports
//   clk_i                  clock
//   rst_ni                 asynchronous active-low reset
//   setback_i              synchronous flush of every outstanding operation
//   apu_slave_req_i        request valid
//   apu_slave_gnt_o        request accepted this cycle (queue not full, no flush)
//   apu_slave_op_i         0 ADD, 1 SUB, 2 MUL, 3 signed MIN
//   apu_slave_lat_i        latency class (1 single, 2 short, 0/3 multicycle)
//   apu_slave_waddr_i      destination tag carried with the operation
//   apu_slave_operand_a_i  operand A
//   apu_slave_operand_b_i  operand B
//   apu_slave_valid_o      response valid
//   apu_slave_ready_i      response consumed when valid and ready
//   apu_slave_result_o     response result
//   apu_slave_waddr_o      response tag
//   busy_o                 at least one operation is queued
// -----------------------------------------------------------------------------
module riscv_apu_slave #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 2,
    parameter int MC_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             setback_i,
    input  logic             apu_slave_req_i,
    output logic             apu_slave_gnt_o,
    input  logic [1:0]       apu_slave_op_i,
    input  logic [1:0]       apu_slave_lat_i,
    input  logic [5:0]       apu_slave_waddr_i,
    input  logic [WIDTH-1:0] apu_slave_operand_a_i,
    input  logic [WIDTH-1:0] apu_slave_operand_b_i,
    output logic             apu_slave_valid_o,
    input  logic             apu_slave_ready_i,
    output logic [WIDTH-1:0] apu_slave_result_o,
    output logic [5:0]       apu_slave_waddr_o,
    output logic             busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Operation encodings.
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // Result of one operation; evaluated once, at accept time.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_MUL:  r = a * b;
            default: r = ($signed(a) < $signed(b)) ? a : b;
        endcase
        return r;
    endfunction

    // Initial countdown for a queued entry. The cycle spent at accept time is
    // already deducted, so an entry with value N becomes eligible N+1 cycles
    // after the accept (never earlier than the next cycle). Classes 1 and 2
    // therefore both start at zero; multicycle waits MC_LAT-1 cycles.
    function automatic logic [3:0] lat_init(input logic [1:0] lat);
        logic [3:0] c;
        case (lat)
            2'd1:    c = 4'd0;
            2'd2:    c = 4'd0;
            default: c = 4'(MC_LAT - 2);
        endcase
        return c;
    endfunction

    // Queue storage and bookkeeping.
    logic [5:0]       tag_q [DEPTH];
    logic [5:0]       tag_d [DEPTH];
    logic [WIDTH-1:0] res_q [DEPTH];
    logic [WIDTH-1:0] res_d [DEPTH];
    logic [3:0]       cnt_q [DEPTH];
    logic [3:0]       cnt_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Handshake decode.
    logic             full_s;
    logic             empty_s;
    logic             gnt_s;
    logic             accept_s;
    logic             bypass_s;
    logic             head_ok_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] result_s;

    // Request-side decode: grant ignores a same-cycle pop so it depends on
    // registered occupancy and the flush input only.
    always_comb begin
        full_s    = (occ_q == OCC_W'(DEPTH));
        empty_s   = (occ_q == '0);
        gnt_s     = !full_s && !setback_i;
        accept_s  = apu_slave_req_i && gnt_s;
        result_s  = alu_result(apu_slave_op_i, apu_slave_operand_a_i,
                               apu_slave_operand_b_i);
        // Bypass is implicitly blocked during a flush because gnt_s is low.
        bypass_s  = empty_s && accept_s && (apu_slave_lat_i == 2'd1)
                    && apu_slave_ready_i;
        // A flush hides the head too, so flushed work never responds.
        head_ok_s = !empty_s && (cnt_q[rd_ptr_q] == 4'd0) && !setback_i;
        push_s    = accept_s && !bypass_s;
        pop_s     = head_ok_s && apu_slave_ready_i;
    end

    // Response-side outputs: bypass wins only when the queue is empty, so it
    // can never collide with a queued head.
    always_comb begin
        apu_slave_gnt_o = gnt_s;
        busy_o          = !empty_s;
        if (bypass_s) begin
            apu_slave_valid_o  = 1'b1;
            apu_slave_result_o = result_s;
            apu_slave_waddr_o  = apu_slave_waddr_i;
        end else begin
            apu_slave_valid_o  = head_ok_s;
            apu_slave_result_o = res_q[rd_ptr_q];
            apu_slave_waddr_o  = tag_q[rd_ptr_q];
        end
    end

    // Next-state logic for the queue: flush, countdown, push, pop, occupancy.
    always_comb begin
        tag_d    = tag_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (setback_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_d[i] = 4'd0;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            // Stale counters of free slots also saturate at zero; they are
            // rewritten on every push, so counting them is harmless.
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != 4'd0) begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                end else begin
                    cnt_d[i] = 4'd0;
                end
            end
            if (push_s) begin
                tag_d[wr_ptr_q] = apu_slave_waddr_i;
                res_d[wr_ptr_q] = result_s;
                cnt_d[wr_ptr_q] = lat_init(apu_slave_lat_i);
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Queue state registers; reset discards every entry asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= 6'd0;
                res_q[i] <= '0;
                cnt_q[i] <= 4'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            tag_q    <= tag_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: tb/tb_riscv_apu_slave.sv
// -----------------------------------------------------------------------------
// Bench for riscv_apu_slave. A driver applies directed scenarios and then
// random traffic. An intake process turns every accepted request into an
// expected response (tag, result, earliest return cycle) in a queue; a monitor
// process decides from that queue whether a response is due and compares what
// the slave presents.
// -----------------------------------------------------------------------------
module tb_riscv_apu_slave;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 2;
    localparam int MC_LAT = 4;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              setback_i = 1'b0;
    logic              req_i = 1'b0;
    logic              gnt_o;
    logic [1:0]        op_i = 2'd0;
    logic [1:0]        lat_i = 2'd0;
    logic [5:0]        waddr_i = 6'd0;
    logic [WIDTH-1:0]  a_i = '0;
    logic [WIDTH-1:0]  b_i = '0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [WIDTH-1:0]  result_o;
    logic [5:0]        waddr_o;
    logic              busy_o;

    riscv_apu_slave #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MC_LAT(MC_LAT)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .setback_i             (setback_i),
        .apu_slave_req_i       (req_i),
        .apu_slave_gnt_o       (gnt_o),
        .apu_slave_op_i        (op_i),
        .apu_slave_lat_i       (lat_i),
        .apu_slave_waddr_i     (waddr_i),
        .apu_slave_operand_a_i (a_i),
        .apu_slave_operand_b_i (b_i),
        .apu_slave_valid_o     (valid_o),
        .apu_slave_ready_i     (ready_i),
        .apu_slave_result_o    (result_o),
        .apu_slave_waddr_o     (waddr_o),
        .busy_o                (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]       tag;
        logic [WIDTH-1:0] res;
        int               due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Count cycles so the model can express return times as absolute cycles.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Reference arithmetic written straight from the operation definitions.
    function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return p[WIDTH-1:0];
            default: return (sa < sb) ? a : b;
        endcase
    endfunction

    // Intake: predict the grant and busy, and log every accepted operation.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            automatic bit   eg = (exp_q.size() < DEPTH) && !setback_i;
            automatic exp_t e;
            check("gnt", gnt_o, eg);
            check("busy", busy_o, exp_q.size() != 0);
            if (req_i && eg) begin
                e.tag = waddr_i;
                e.res = ref_op(op_i, a_i, b_i);
                if (exp_q.size() == 0 && lat_i == 2'd1 && ready_i)
                    e.due = cyc;
                else if (lat_i == 2'd1 || lat_i == 2'd2)
                    e.due = cyc + 1;
                else
                    e.due = cyc + MC_LAT - 1;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: the oldest outstanding operation must be presented exactly
    // when it is due; flushed operations are dropped without a response.
    always @(negedge clk) begin
        #1;
        if (!rst_ni) begin
            exp_q.delete();
        end else begin
            automatic bit ev = !setback_i && exp_q.size() > 0 && exp_q[0].due <= cyc;
            check("valid", valid_o, ev);
            if (ev && valid_o) begin
                check("result", result_o, exp_q[0].res);
                check("waddr", waddr_o, exp_q[0].tag);
            end
            if (ev && ready_i) void'(exp_q.pop_front());
            if (setback_i) exp_q.delete();
        end
    end

    task automatic drive(input logic req, input logic [1:0] op, input logic [1:0] lat,
                         input logic [5:0] tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic rdy, input logic sb);
        @(posedge clk);
        #1;
        req_i = req; op_i = op; lat_i = lat; waddr_i = tag;
        a_i = a; b_i = b; ready_i = rdy; setback_i = sb;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 2'd0, 6'd0, '0, '0, rdy, 1'b0);
    endtask

    // Async reset between edges: outputs must drop to the reset state at once.
    task automatic async_reset(input string tagname);
        #1;
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check({tagname, "_valid"}, valid_o, 0);
        check({tagname, "_gnt"}, gnt_o, 1);
        check({tagname, "_busy"}, busy_o, 0);
        check({tagname, "_result"}, result_o, 0);
        check({tagname, "_waddr"}, waddr_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] rnd_operand();
        case ($urandom_range(3))
            0:       return WIDTH'($urandom_range(15));
            1:       return -WIDTH'($urandom_range(15));
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial begin
        // Reset state while held in reset.
        #2;
        check("rst_valid", valid_o, 0);
        check("rst_gnt", gnt_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_result", result_o, 0);
        check("rst_waddr", waddr_o, 0);
        #10;
        rst_ni = 1'b1;
        idle(2, 1'b1);

        // Same-cycle bypass: ADD 5+7 -> 12, tag 3.
        drive(1'b1, 2'd0, 2'd1, 6'd3, 32'd5, 32'd7, 1'b1, 1'b0);
        #2;
        check("bypass_valid", valid_o, 1);
        check("bypass_result", result_o, 32'd12);
        idle(2, 1'b1);

        // Multicycle MUL 0x10000*0x10000 -> 0, tag 9.
        drive(1'b1, 2'd2, 2'd3, 6'd9, 32'h10000, 32'h10000, 1'b1, 1'b0);
        idle(6, 1'b1);

        // In-order: long SUB ahead of short MIN.
        drive(1'b1, 2'd1, 2'd3, 6'd1, 32'd1, 32'd2, 1'b1, 1'b0);
        drive(1'b1, 2'd3, 2'd2, 6'd2, -32'd3, 32'd4, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Backpressure: fill the queue, hold the third request, then drain.
        drive(1'b1, 2'd0, 2'd2, 6'd10, 32'd1, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 2'd2, 6'd11, 32'd9, 32'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 2'd2, 2'd2, 6'd12, 32'd6, 32'd7, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 2'd2, 6'd12, 32'd6, 32'd7, 1'b1, 1'b0);
        drive(1'b1, 2'd2, 2'd2, 6'd12, 32'd6, 32'd7, 1'b1, 1'b0);
        idle(5, 1'b1);

        // Flush two outstanding multicycle operations.
        drive(1'b1, 2'd0, 2'd3, 6'd20, 32'd1, 32'd2, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 2'd0, 6'd21, 32'd3, 32'd4, 1'b1, 1'b0);
        drive(1'b1, 2'd0, 2'd1, 6'd22, 32'd5, 32'd6, 1'b1, 1'b1);
        idle(6, 1'b1);

        // Async reset while full with a response on the bus.
        drive(1'b1, 2'd0, 2'd1, 6'd30, 32'd1, 32'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd0, 2'd1, 6'd31, 32'd2, 32'd2, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 2'd0, 6'd0, '0, '0, 1'b0, 1'b0);
        #1;
        check("full_valid", valid_o, 1);
        async_reset("midrst");
        idle(3, 1'b1);

        // Random traffic with occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(9) < 6), 2'($urandom_range(3)), 2'($urandom_range(3)),
                  6'($urandom_range(63)), rnd_operand(), rnd_operand(),
                  ($urandom_range(9) < 7), ($urandom_range(49) == 0));
            if ($urandom_range(499) == 0) async_reset("rndrst");
        end

        // Drain and confirm nothing is left outstanding.
        idle(MC_LAT + 4, 1'b1);
        #3;
        check("drain_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
